// File: rtl/sprite_mover.sv
// Moves a sprite centre on directional-button ticks with wrap/clamp/bounce
// edge handling, and paints the sprite over a background one cycle after scan.
module sprite_mover #(
  parameter int          HALF_W = 5,
  parameter int          HALF_H = 5,
  parameter int          STEP   = 2,
  parameter int          DIV    = 4,
  parameter int          X_MIN  = 144,
  parameter int          X_MAX  = 783,
  parameter int          Y_MIN  = 35,
  parameter int          Y_MAX  = 515,
  parameter int          X_RST  = 464,
  parameter int          Y_RST  = 275,
  parameter int          MODE   = 0,
  parameter logic [11:0] COLOR  = 12'hF00,
  parameter logic [11:0] BG     = 12'h015
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bright,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        fill,
  output logic [11:0] rgb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  // Mode 3 has no meaning of its own and behaves as clamp.
  localparam int EMODE = (MODE == 3) ? 1 : MODE;
  localparam bit WRAP  = (EMODE == 0);

  localparam logic [10:0] S11    = 11'(STEP);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMIN11 = 11'(Y_MIN);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);
  localparam logic [10:0] XLO11  = 11'(X_MIN + STEP);
  localparam logic [10:0] YLO11  = 11'(Y_MIN + STEP);
  localparam logic [10:0] HW11   = 11'(HALF_W);
  localparam logic [10:0] HH11   = 11'(HALF_H);

  logic [CW-1:0] tick_cnt;
  logic          move_tick;
  logic          dx;
  logic          dy;
  logic [10:0]   x11, y11, h11, v11, nx, ny;
  logic          ndx, ndy;
  logic          in_sprite;

  assign move_tick = (tick_cnt == CW'(DIV - 1));
  assign x11 = {1'b0, xpos};
  assign y11 = {1'b0, ypos};
  assign h11 = {1'b0, hCount};
  assign v11 = {1'b0, vCount};

  assign in_sprite = (h11 + HW11 >= x11) && (h11 <= x11 + HW11) &&
                     (v11 + HH11 >= y11) && (v11 <= y11 + HH11);

  // Bound tests compare against MIN+STEP so the subtraction never underflows.
  always_comb begin
    nx  = x11;
    ny  = y11;
    ndx = dx;
    ndy = dy;
    if (EMODE == 2) begin
      if (right)     ndx = 1'b1;
      else if (left) ndx = 1'b0;
      if (up)        ndy = 1'b0;
      else if (down) ndy = 1'b1;
      if (ndx) begin
        if (x11 + S11 > XMAX11) begin nx = XMAX11; ndx = 1'b0; end
        else nx = x11 + S11;
      end else begin
        if (x11 < XLO11) begin nx = XMIN11; ndx = 1'b1; end
        else nx = x11 - S11;
      end
      if (ndy) begin
        if (y11 + S11 > YMAX11) begin ny = YMAX11; ndy = 1'b0; end
        else ny = y11 + S11;
      end else begin
        if (y11 < YLO11) begin ny = YMIN11; ndy = 1'b1; end
        else ny = y11 - S11;
      end
    end else begin
      if (right)
        nx = (x11 + S11 > XMAX11) ? (WRAP ? XMIN11 : XMAX11) : x11 + S11;
      else if (left)
        nx = (x11 < XLO11) ? (WRAP ? XMAX11 : XMIN11) : x11 - S11;
      else if (up)
        ny = (y11 < YLO11) ? (WRAP ? YMAX11 : YMIN11) : y11 - S11;
      else if (down)
        ny = (y11 + S11 > YMAX11) ? (WRAP ? YMIN11 : YMAX11) : y11 + S11;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      xpos     <= 10'(X_RST);
      ypos     <= 10'(Y_RST);
      dx       <= 1'b1;
      dy       <= 1'b1;
      fill     <= 1'b0;
      rgb      <= '0;
    end else begin
      tick_cnt <= move_tick ? '0 : tick_cnt + CW'(1);
      if (move_tick) begin
        xpos <= nx[9:0];
        ypos <= ny[9:0];
        dx   <= ndx;
        dy   <= ndy;
      end
      fill <= in_sprite;
      rgb  <= !bright ? 12'h000 : (in_sprite ? COLOR : BG);
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench: four sprite_mover variants (wrap, wrap near edge,
// clamp via mode 3, bounce) compared every cycle against an arithmetic model.
module tb_sprite_mover;

  localparam int          STEP  = 2;
  localparam int          DIV   = 4;
  localparam int          HW    = 5;
  localparam int          HH    = 5;
  localparam int          XMIN  = 144;
  localparam int          XMAX  = 783;
  localparam int          YMIN  = 35;
  localparam int          YMAX  = 515;
  localparam logic [11:0] COLOR = 12'hF00;
  localparam logic [11:0] BG    = 12'h015;

  // Effective edge behaviour per instance: 0 wrap, 1 clamp, 2 bounce.
  localparam int MODE_A [4] = '{0, 0, 1, 2};
  localparam int XR_A   [4] = '{464, 782, 780, 782};
  localparam int YR_A   [4] = '{275, 275, 36, 37};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bright = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [9:0] hCount = '0, vCount = '0;

  logic [9:0]  xo [4];
  logic [9:0]  yo [4];
  logic        fo [4];
  logic [11:0] ro [4];

  int mx [4];
  int my [4];
  int mdx [4];
  int mdy [4];
  logic        efill [4];
  logic [11:0] ergb [4];
  int mcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_mover u_wrap (
    .clk(clk), .rst(rst), .bright(bright), .up(up), .down(down), .left(left), .right(right),
    .hCount(hCount), .vCount(vCount), .xpos(xo[0]), .ypos(yo[0]), .fill(fo[0]), .rgb(ro[0]));

  sprite_mover #(.X_RST(782)) u_wrap2 (
    .clk(clk), .rst(rst), .bright(bright), .up(up), .down(down), .left(left), .right(right),
    .hCount(hCount), .vCount(vCount), .xpos(xo[1]), .ypos(yo[1]), .fill(fo[1]), .rgb(ro[1]));

  sprite_mover #(.MODE(3), .X_RST(780), .Y_RST(36)) u_clamp (
    .clk(clk), .rst(rst), .bright(bright), .up(up), .down(down), .left(left), .right(right),
    .hCount(hCount), .vCount(vCount), .xpos(xo[2]), .ypos(yo[2]), .fill(fo[2]), .rgb(ro[2]));

  sprite_mover #(.MODE(2), .X_RST(782), .Y_RST(37)) u_bounce (
    .clk(clk), .rst(rst), .bright(bright), .up(up), .down(down), .left(left), .right(right),
    .hCount(hCount), .vCount(vCount), .xpos(xo[3]), .ypos(yo[3]), .fill(fo[3]), .rgb(ro[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int boundMove(int mode, int pos, int d, int lo, int hi);
    int t;
    t = pos + d * STEP;
    if (t > hi) return (mode == 0) ? lo : hi;
    if (t < lo) return (mode == 0) ? hi : lo;
    return t;
  endfunction

  task automatic modelReset();
    mcnt = 0;
    for (int k = 0; k < 4; k++) begin
      mx[k] = XR_A[k];
      my[k] = YR_A[k];
      mdx[k] = 1;
      mdy[k] = 1;
      efill[k] = 1'b0;
      ergb[k] = 12'h000;
    end
  endtask

  // Drive inputs for the coming rising edge and predict its effect.
  task automatic applyStimulus(input bit r, input bit l, input bit u, input bit d,
                               input int h, input int v, input bit b);
    bit tick;
    int t;
    right = r; left = l; up = u; down = d;
    hCount = 10'(h); vCount = 10'(v); bright = b;
    tick = (mcnt == DIV - 1);
    mcnt = tick ? 0 : mcnt + 1;
    for (int k = 0; k < 4; k++) begin
      efill[k] = (h + HW >= mx[k]) && (h <= mx[k] + HW) &&
                 (v + HH >= my[k]) && (v <= my[k] + HH);
      ergb[k] = !b ? 12'h000 : (efill[k] ? COLOR : BG);
      if (tick) begin
        if (MODE_A[k] == 2) begin
          if (r) mdx[k] = 1; else if (l) mdx[k] = -1;
          if (u) mdy[k] = -1; else if (d) mdy[k] = 1;
          t = mx[k] + mdx[k] * STEP;
          if (t > XMAX) begin mx[k] = XMAX; mdx[k] = -1; end
          else if (t < XMIN) begin mx[k] = XMIN; mdx[k] = 1; end
          else mx[k] = t;
          t = my[k] + mdy[k] * STEP;
          if (t > YMAX) begin my[k] = YMAX; mdy[k] = -1; end
          else if (t < YMIN) begin my[k] = YMIN; mdy[k] = 1; end
          else my[k] = t;
        end else if (r) mx[k] = boundMove(MODE_A[k], mx[k], 1, XMIN, XMAX);
        else if (l)     mx[k] = boundMove(MODE_A[k], mx[k], -1, XMIN, XMAX);
        else if (u)     my[k] = boundMove(MODE_A[k], my[k], -1, YMIN, YMAX);
        else if (d)     my[k] = boundMove(MODE_A[k], my[k], 1, YMIN, YMAX);
      end
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("xpos[%0d]", k), 32'(xo[k]), 32'(mx[k]));
      chk($sformatf("ypos[%0d]", k), 32'(yo[k]), 32'(my[k]));
      chk($sformatf("fill[%0d]", k), 32'(fo[k]), 32'(efill[k]));
      chk($sformatf("rgb[%0d]", k), 32'(ro[k]), 32'(ergb[k]));
    end
  endtask

  task automatic step(input int n, input bit r, input bit l, input bit u, input bit d,
                      input int h, input int v, input bit b);
    for (int i = 0; i < n; i++) begin
      applyStimulus(r, l, u, d, h, v, b);
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int k, h, v;
    $display("[TB] sprite_mover bench starting");
    #2;
    doReset();

    // Wrap at both horizontal edges.
    step(4, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_right_x", 32'(xo[1]), 32'd144);
    step(4, 0, 1, 0, 0, 0, 0, 0);
    chk("wrap_left_x", 32'(xo[1]), 32'd783);

    // Clamp (mode 3) holds at the top edge.
    for (int i = 0; i < 3; i++) begin
      step(4, 0, 0, 1, 0, 0, 0, 0);
      chk($sformatf("clamp_up_y%0d", i), 32'(yo[2]), 32'd35);
    end

    // Ten right ticks from reset, spaced DIV cycles apart.
    doReset();
    step(39, 1, 0, 0, 0, 0, 0, 0);
    chk("ten_ticks_pre_x", 32'(xo[0]), 32'd482);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("ten_ticks_x", 32'(xo[0]), 32'd484);
    chk("ten_ticks_y", 32'(yo[0]), 32'd275);

    // Bounce off the right edge, then redirect both axes at once.
    doReset();
    step(4, 0, 0, 0, 0, 0, 0, 0);
    chk("bounce_hit_x", 32'(xo[3]), 32'd783);
    step(4, 0, 0, 0, 0, 0, 0, 0);
    chk("bounce_back_x", 32'(xo[3]), 32'd781);
    step(4, 1, 0, 1, 0, 0, 0, 0);
    chk("bounce_ur_x", 32'(xo[3]), 32'd783);
    chk("bounce_ur_y", 32'(yo[3]), 32'd39);
    step(4, 0, 0, 0, 0, 0, 0, 0);
    chk("bounce_after_y", 32'(yo[3]), 32'd37);

    // Pixel edge of the sprite and blanking.
    doReset();
    step(1, 0, 0, 0, 0, 459, 270, 1);
    chk("pix_in_fill", 32'(fo[0]), 32'd1);
    chk("pix_in_rgb", 32'(ro[0]), 32'hF00);
    step(1, 0, 0, 0, 0, 458, 270, 1);
    chk("pix_out_fill", 32'(fo[0]), 32'd0);
    chk("pix_out_rgb", 32'(ro[0]), 32'h015);
    step(1, 0, 0, 0, 0, 459, 270, 0);
    chk("pix_blank_rgb", 32'(ro[0]), 32'h000);

    // Reset mid-count while moving discards the pending move.
    doReset();
    step(6, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_x", 32'(xo[0]), 32'd466);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_x", 32'(xo[0]), 32'd464);
    doReset();
    step(3, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_hold_x", 32'(xo[0]), 32'd464);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_tick_x", 32'(xo[0]), 32'd466);

    // Random buttons and scan positions near one of the sprites.
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 3));
      h = mx[k] + int'($urandom_range(0, 20)) - 10;
      v = my[k] + int'($urandom_range(0, 20)) - 10;
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (h > 1023) h = 1023;
      if (v > 1023) v = 1023;
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), h, v, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
